// File: rtl/cpu_pkg.sv
// Types and constants shared by the instruction fetch front end.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        S_BOOT,
        S_FETCH
    } ifetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode; flush wins over push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic                               push,
    input  fetch_entry_t                       push_data,
    input  logic                               pop,
    output fetch_entry_t                       head,
    output logic [$clog2(FIFO_DEPTH + 1)-1:0]  count,
    output logic                               full,
    output logic                               empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_entry_t  mem_q [FIFO_DEPTH];
    fetch_entry_t  mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A full buffer may still accept a write when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem reads, buffers responses
// for decode and discards responses that were already in flight at a redirect.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fetch_en,
    input  logic                              redirect_valid,
    input  logic [31:0]                       redirect_pc,
    output logic                              imem_req_valid,
    input  logic                              imem_req_ready,
    output logic [31:0]                       imem_addr,
    input  logic                              imem_rsp_valid,
    input  logic [31:0]                       imem_rsp_data,
    output logic                              instr_valid,
    input  logic                              instr_ready,
    output logic [31:0]                       instr,
    output logic [31:0]                       instr_pc,
    output logic [$clog2(MAX_OUTST + 1)-1:0]  outst_cnt
);

    localparam int                CNT_W       = $clog2(MAX_OUTST + 1);
    localparam int                FCW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  MAX_OUTST_C = CNT_W'(MAX_OUTST);

    ifetch_state_e    state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outst_cnt_q, outst_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [FCW-1:0]   fifo_count;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    fetch_entry_t     fifo_head, push_entry;
    logic             has_credit, issue, rsp_take;
    logic             unused_bits;

    assign unused_bits = ^{redirect_pc[1:0], fifo_full};

    // Every outstanding request owns a future FIFO slot, so responses can never overflow it.
    assign has_credit = (outst_cnt_q < MAX_OUTST_C) &&
                        ((32'(outst_cnt_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH));

    assign imem_req_valid = (state_q == S_FETCH) && fetch_en && !redirect_valid && has_credit;
    assign imem_addr      = fetch_pc_q;
    assign issue          = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (outst_cnt_q != '0);
    assign push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        state_d     = S_FETCH;
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        outst_cnt_d = outst_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        fifo_push   = 1'b0;
        if (redirect_valid) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            rsp_pc_d    = {redirect_pc[31:2], 2'b00};
            outst_cnt_d = outst_cnt_q - CNT_W'(rsp_take);
            drop_cnt_d  = outst_cnt_q - CNT_W'(rsp_take);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            outst_cnt_d = outst_cnt_q + CNT_W'(issue) - CNT_W'(rsp_take);
            if (rsp_take) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                    rsp_pc_d  = rsp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_BOOT;
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            outst_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            outst_cnt_q <= outst_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // A redirect cycle flushes the buffer, so a decode handshake in it is void.
    assign fifo_pop = instr_valid && instr_ready && !redirect_valid;

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign outst_cnt   = outst_cnt_q;

`ifndef SYNTHESIS
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outst_cnt_q != '0));
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: in-order imem model, sequential-PC reference for decode.
module tb_ifetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_K  = 32'hA5A5_0000;

    logic        clk, rst_n, fetch_en, redirect_valid;
    logic [31:0] redirect_pc, imem_addr, imem_rsp_data, instr, instr_pc;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic        instr_valid, instr_ready;
    logic [1:0]  outst_cnt;

    ifetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2),
        .MAX_OUTST  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .outst_cnt      (outst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          total = 0, bad = 0;
    int          cyc = 0, last_due = 0, n_issued = 0, n_pops = 0;
    int          lat_min = 1, lat_max = 1, rdy_mode = 0, dec_mode = 0;
    logic        fe = 1'b1, redir = 1'b0;
    logic [31:0] redir_tgt = '0;
    logic [31:0] exp_pc, exp_req, hold_addr, last_pop_pc;
    logic        hold_prev = 1'b0, post_redir = 1'b0, seen_wrap = 1'b0;
    logic        s_req_valid, s_popped, s_rsp;
    logic [31:0] s_req_addr, s_pop_pc;
    logic        found, got_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_valid"},   32'(imem_req_valid), 32'd0);
        chk({tag, "_instr_valid"}, 32'(instr_valid),    32'd0);
        chk({tag, "_instr"},       instr,               32'd0);
        chk({tag, "_instr_pc"},    instr_pc,            32'd0);
        chk({tag, "_imem_addr"},   imem_addr,           RST_PC);
        chk({tag, "_outst"},       32'(outst_cnt),      32'd0);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        mq.delete();
        last_due   = 0;
        hold_prev  = 1'b0;
        post_redir = 1'b0;
        redir      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        rst_n       = 1'b1;
        cyc         = 1;
        exp_pc      = RST_PC;
        exp_req     = RST_PC;
        n_issued    = 0;
        n_pops      = 0;
        last_pop_pc = 32'h0000_0001;
    endtask

    // One clock: drive inputs after the falling edge, observe 1ns later, advance.
    task automatic step();
        int lat, due;
        redirect_valid = redir;
        redirect_pc    = redir_tgt;
        fetch_en       = fe;
        case (rdy_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'($urandom_range(0, 1));
            default: imem_req_ready = ((cyc % 3) != 1);
        endcase
        case (dec_mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = 1'b0;
            default: instr_ready = 1'($urandom_range(0, 1));
        endcase
        s_rsp = 1'b0;
        if (mq.size() > 0) s_rsp = (mq[0].due <= cyc);
        imem_rsp_valid = s_rsp;
        if (s_rsp) imem_rsp_data = mq[0].addr ^ XOR_K;
        else       imem_rsp_data = $urandom();
        #1;
        chk("outst_cnt", 32'(outst_cnt), 32'(mq.size()));
        chk("outst_le_max", 32'(outst_cnt <= 2'd2), 32'd1);
        if (post_redir) chk("instr_valid_after_redirect", 32'(instr_valid), 32'd0);
        if (hold_prev && fetch_en && !redirect_valid) begin
            chk("req_held", 32'(imem_req_valid), 32'd1);
            chk("req_addr_held", imem_addr, hold_addr);
        end
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_addr;
        s_popped    = 1'b0;
        if (redirect_valid) begin
            chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
            exp_pc  = {redir_tgt[31:2], 2'b00};
            exp_req = exp_pc;
        end else begin
            if (imem_req_valid) chk("req_addr", imem_addr, exp_req);
            if (imem_req_valid && imem_req_ready) begin
                lat = int'($urandom_range(lat_min, lat_max));
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: imem_addr, due: due});
                exp_req = exp_req + 32'd4;
                n_issued++;
            end
            if (instr_valid && instr_ready) begin
                chk("instr_pc", instr_pc, exp_pc);
                chk("instr_data", instr, exp_pc ^ XOR_K);
                if (instr_pc == 32'd0 && last_pop_pc == 32'hFFFF_FFFC) seen_wrap = 1'b1;
                last_pop_pc = instr_pc;
                s_popped    = 1'b1;
                s_pop_pc    = instr_pc;
                exp_pc      = exp_pc + 32'd4;
                n_pops++;
            end
        end
        hold_prev  = imem_req_valid && !imem_req_ready && fetch_en;
        hold_addr  = imem_addr;
        post_redir = redirect_valid;
        if (s_rsp) void'(mq.pop_front());
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redir = 1'b0;
    endtask

    initial begin
        // Basic stream: boot cycle, first request, first delivery, sustained flow
        do_reset();
        fe = 1'b1; rdy_mode = 0; dec_mode = 0; lat_min = 1; lat_max = 1;
        step();
        chk("boot_no_req", 32'(s_req_valid), 32'd0);
        step();
        chk("first_req_valid", 32'(s_req_valid), 32'd1);
        chk("first_req_addr", s_req_addr, 32'h0);
        step();
        step();
        chk("first_pop", 32'(s_popped), 32'd1);
        chk("first_pop_pc", s_pop_pc, 32'h0);
        repeat (30) step();
        chk("stream_progress", 32'(n_pops >= 15), 32'd1);

        // Decode stalled: credit stops issue after two requests
        do_reset();
        dec_mode = 1;
        repeat (12) step();
        chk("stall_issued", 32'(n_issued), 32'd2);
        chk("stall_no_req", 32'(s_req_valid), 32'd0);
        chk("stall_head_valid", 32'(instr_valid), 32'd1);
        chk("stall_head_pc", instr_pc, 32'h0);
        dec_mode = 0;
        repeat (20) step();
        chk("stall_resume", 32'(n_pops >= 8), 32'd1);

        // Redirect with 0x10 and 0x14 both in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mq.size() == 2 && mq[0].addr == 32'h10 && mq[1].addr == 32'h14) found = 1'b1;
            else step();
        end
        chk("inflight_10_14", 32'(found), 32'd1);
        redir = 1'b1; redir_tgt = 32'h0000_0103;
        step();
        found = 1'b0; got_req = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (s_req_valid && !got_req) begin
                got_req = 1'b1;
                chk("redir_first_req", s_req_addr, 32'h100);
            end
            if (s_popped) begin
                found = 1'b1;
                chk("redir_first_pop", s_pop_pc, 32'h100);
            end
        end
        chk("redir_pop_seen", 32'(found), 32'd1);

        // Redirect coinciding with the 0x8 response and a decode pop
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (4) step();
        dec_mode = 1;
        step();
        dec_mode = 0;
        chk("pre_rsp8", 32'(mq.size() == 1 && mq[0].addr == 32'h8 && mq[0].due <= cyc), 32'd1);
        chk("pre_head4", 32'(instr_valid && instr_pc == 32'h4), 32'd1);
        redir = 1'b1; redir_tgt = 32'h0000_0040;
        step();
        chk("redir_rsp_same_cycle", 32'(s_rsp), 32'd1);
        repeat (12) step();
        chk("after_redir_progress", 32'(n_pops >= 4), 32'd1);

        // Toggling req_ready with 3-cycle latency
        do_reset();
        rdy_mode = 2; lat_min = 3; lat_max = 3;
        repeat (40) step();
        chk("toggle_progress", 32'(n_pops >= 5), 32'd1);

        // Redirect during boot to just below the wrap point
        do_reset();
        rdy_mode = 0; lat_min = 1; lat_max = 1; seen_wrap = 1'b0;
        redir = 1'b1; redir_tgt = 32'hFFFF_FFF9;
        step();
        step();
        chk("boot_redir_req", 32'(s_req_valid), 32'd1);
        chk("boot_redir_addr", s_req_addr, 32'hFFFF_FFF8);
        repeat (15) step();
        chk("pc_wrap", 32'(seen_wrap), 32'd1);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) begin
                rdy_mode = int'($urandom_range(0, 2));
                dec_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
                lat_min  = 1;
                lat_max  = int'($urandom_range(1, 4));
            end
            fe = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redir     = 1'b1;
                redir_tgt = $urandom();
            end
            step();
        end
        chk("random_progress", 32'(n_pops >= 50), 32'd1);

        // Asynchronous reset mid-stream
        fe = 1'b1; rdy_mode = 0; dec_mode = 0; lat_min = 2; lat_max = 2;
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        do_reset();
        repeat (10) step();
        chk("post_reset_progress", 32'(n_pops >= 3), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
